// File: rtl/vga_pkg.sv
// Shared raster timing defaults, coordinate type and sync polarity for the VGA timing block.
package vga_pkg;
  localparam int unsigned COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE_DEF = 1024;
  localparam int unsigned H_FP_DEF      = 24;
  localparam int unsigned H_SYNC_DEF    = 136;
  localparam int unsigned H_BP_DEF      = 160;
  localparam int unsigned V_VISIBLE_DEF = 768;
  localparam int unsigned V_FP_DEF      = 3;
  localparam int unsigned V_SYNC_DEF    = 6;
  localparam int unsigned V_BP_DEF      = 29;
  localparam int unsigned PIPE_DLY_DEF  = 2;

  localparam logic SYNC_ACTIVE_LOW = 1'b0;

  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c < hi);
  endfunction
endpackage

// File: rtl/sync_delay_line.sv
// Shift register of DEPTH stages; advances only on en, every stage loads RST_VAL on rst.
// Latency DEPTH enabled steps; holds its contents while en is low.
module sync_delay_line #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else if (en) begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters with registered coordinate, sync, visible and frame-start decodes (one enabled step of latency),
// plus a PIPE_DLY-deep delayed copy of sync/visible. Everything freezes while en is low; frame_start drops to 0.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter logic        SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int unsigned PIPE_DLY  = PIPE_DLY_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   visible,
  output logic   hsync,
  output logic   vsync,
  output logic   frame_start,
  output logic   hsync_d,
  output logic   vsync_d,
  output logic   visible_d
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W) || PIPE_DLY < 1 || PIPE_DLY > 8)
  begin : g_bad_cfg
    $error("vga_timing_gen: totals must fit in 11 bits and PIPE_DLY must be 1..8");
  end

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_END = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SYNC_END = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  coord_t px_q, py_q;
  logic   vis_q, vis_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
    vis_d = (hcnt_q < H_VIS_END) && (vcnt_q < V_VIS_END);
    hs_d  = in_window(hcnt_q, H_SYNC_BEG, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vs_d  = in_window(vcnt_q, V_SYNC_BEG, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    fs_d  = (hcnt_q == '0) && (vcnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      px_q   <= '0;
      py_q   <= '0;
      vis_q  <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      fs_q   <= 1'b0;
    end else if (en) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      px_q   <= hcnt_q;
      py_q   <= vcnt_q;
      vis_q  <= vis_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
    end else begin
      fs_q   <= 1'b0;
    end
  end

  // The delay line taps the registered outputs, so its reset value matches theirs.
  logic [2:0] dly_out;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  ({hs_q, vs_q, vis_q}),
    .dout (dly_out)
  );

  assign {hsync_d, vsync_d, visible_d} = dly_out;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign visible     = vis_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of vga_timing_gen: default timing for line-level boundaries, and a small
// active-high-sync instance (16x11 raster, PIPE_DLY=3) for frame wrap, vsync, reset and en gating.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst, en;

  logic [10:0] pixel_x, pixel_y, s_x, s_y;
  logic visible, hsync, vsync, frame_start, hsync_d, vsync_d, visible_d;
  logic s_vis, s_hs, s_vs, s_fs, s_hsd, s_vsd, s_visd;

  int tests_run = 0, tests_failed = 0;
  int sn = 0, cyc = 0, hs_low = 0, last_fs = 0, fs_seen = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .rst(rst), .en(en),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .visible(visible),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .hsync_d(hsync_d), .vsync_d(vsync_d), .visible_d(visible_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .PIPE_DLY(3)
  ) u_small (
    .clk(clk), .rst(rst), .en(en),
    .pixel_x(s_x), .pixel_y(s_y), .visible(s_vis),
    .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs),
    .hsync_d(s_hsd), .vsync_d(s_vsd), .visible_d(s_visd)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (step %0d, cycle %0d)", tag, got, exp, sn, cyc);
    end
  endtask

  // Small raster: 16 pixels x 11 lines = 176 steps/frame; n = enabled steps since reset, 0 = reset state.
  function automatic int sx(input int n);
    return (n <= 0) ? 0 : ((n - 1) % 176) % 16;
  endfunction
  function automatic int sy(input int n);
    return (n <= 0) ? 0 : ((n - 1) % 176) / 16;
  endfunction
  function automatic int svis(input int n);
    return (n <= 0) ? 0 : int'(sx(n) < 8 && sy(n) < 6);
  endfunction
  function automatic int shs(input int n);
    return (n <= 0) ? 0 : int'(sx(n) >= 10 && sx(n) < 13);
  endfunction
  function automatic int svs(input int n);
    return (n <= 0) ? 0 : int'(sy(n) >= 7 && sy(n) < 9);
  endfunction

  task automatic check_small(input logic fired);
    check_eq("s_x", s_x, sx(sn));
    check_eq("s_y", s_y, sy(sn));
    check_eq("s_visible", s_vis, svis(sn));
    check_eq("s_hsync", s_hs, shs(sn));
    check_eq("s_vsync", s_vs, svs(sn));
    check_eq("s_frame_start", s_fs, int'(fired && sn >= 1 && sx(sn) == 0 && sy(sn) == 0));
    check_eq("s_hsync_d", s_hsd, shs(sn - 3));
    check_eq("s_vsync_d", s_vsd, svs(sn - 3));
    check_eq("s_visible_d", s_visd, svis(sn - 3));
  endtask

  task automatic tick(input logic e);
    en = e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) sn = 0;
    else if (e) sn++;
    check_small(e && !rst);
  endtask

  task automatic check_dut_reset(input string tag);
    check_eq({tag, "_x"}, pixel_x, 0);
    check_eq({tag, "_y"}, pixel_y, 0);
    check_eq({tag, "_visible"}, visible, 0);
    check_eq({tag, "_frame_start"}, frame_start, 0);
    check_eq({tag, "_hsync"}, hsync, 1);
    check_eq({tag, "_vsync"}, vsync, 1);
    check_eq({tag, "_hsync_d"}, hsync_d, 1);
    check_eq({tag, "_vsync_d"}, vsync_d, 1);
    check_eq({tag, "_visible_d"}, visible_d, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    check_dut_reset("rst");

    rst = 1'b0;
    while (sn < 2445 && cyc < 5000) begin
      tick(1'b1);
      if (sn <= 1344 && hsync == 1'b0) hs_low++;
      case (sn)
        1: begin
          check_eq("first_x", pixel_x, 0);
          check_eq("first_y", pixel_y, 0);
          check_eq("first_visible", visible, 1);
          check_eq("first_frame_start", frame_start, 1);
          check_eq("first_hsync", hsync, 1);
          check_eq("first_vsync", vsync, 1);
          check_eq("first_hsync_d", hsync_d, 1);
          check_eq("first_vsync_d", vsync_d, 1);
          check_eq("first_visible_d", visible_d, 0);
        end
        2: begin
          check_eq("step2_x", pixel_x, 1);
          check_eq("step2_frame_start", frame_start, 0);
          check_eq("step2_visible_d", visible_d, 0);
        end
        3:    check_eq("step3_visible_d", visible_d, 1);
        1024: begin check_eq("x1023", pixel_x, 1023); check_eq("x1023_visible", visible, 1); end
        1025: begin check_eq("x1024", pixel_x, 1024); check_eq("x1024_visible", visible, 0); end
        1048: begin check_eq("x1047", pixel_x, 1047); check_eq("x1047_hsync", hsync, 1); end
        1049: begin check_eq("x1048", pixel_x, 1048); check_eq("x1048_hsync", hsync, 0); end
        1050: check_eq("x1049_hsync_d", hsync_d, 1);
        1051: check_eq("x1050_hsync_d", hsync_d, 0);
        1184: begin check_eq("x1183", pixel_x, 1183); check_eq("x1183_hsync", hsync, 0); end
        1185: begin check_eq("x1184", pixel_x, 1184); check_eq("x1184_hsync", hsync, 1); end
        1344: begin
          check_eq("x1343", pixel_x, 1343);
          check_eq("x1343_y", pixel_y, 0);
          check_eq("hsync_low_len", hs_low, 136);
        end
        1345: begin
          check_eq("wrap_x", pixel_x, 0);
          check_eq("wrap_y", pixel_y, 1);
          check_eq("wrap_visible", visible, 1);
          check_eq("wrap_frame_start", frame_start, 0);
        end
        2445: begin
          check_eq("pre_rst_x", pixel_x, 1100);
          check_eq("pre_rst_y", pixel_y, 1);
          check_eq("pre_rst_hsync", hsync, 0);
        end
        default: ;
      endcase
    end
    check_eq("phase_a_steps", sn, 2445);

    // Reset lands mid hsync pulse on both instances.
    rst = 1'b1;
    tick(1'b1);
    check_dut_reset("midrst");
    rst = 1'b0;
    tick(1'b1);
    check_eq("resume_x", pixel_x, 0);
    check_eq("resume_y", pixel_y, 0);
    check_eq("resume_visible", visible, 1);
    check_eq("resume_frame_start", frame_start, 1);

    last_fs = cyc;
    for (int i = 0; i < 800; i++) begin
      tick(i % 2 == 1);
      check_eq("gate_x", pixel_x, (sn - 1) % 1344);
      check_eq("gate_visible", visible, int'(((sn - 1) % 1344) < 1024));
      if (i % 2 == 0) check_eq("gate_frame_start_off", frame_start, 0);
      if (s_fs == 1'b1) begin
        check_eq("s_fs_period", cyc - last_fs, 352);
        last_fs = cyc;
        fs_seen++;
      end
    end
    check_eq("s_fs_count", fs_seen, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
